// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM state
// encoding, ALU control codes, instruction field constants and datapath
// mux select codes.
package mips_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_RWB    = 4'd4,
      S_MEMADR = 4'd5,
      S_MEMRD  = 4'd6,
      S_MEMWB  = 4'd7,
      S_MEMWR  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ADDIEX = 4'd11,
      S_ADDIWB = 4'd12,
      S_TRAP   = 4'd13
   } state_e;

   // ALU operation select driven on alu_cs
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;

   // ALU operand A select
   localparam logic SRC_A_PC  = 1'b0;
   localparam logic SRC_A_REG = 1'b1;

   // ALU operand B select
   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type function-field decoder: maps funct to an ALU control code and flags
// encodings this core does not implement. Purely combinational so any
// control block can reuse it.
module mc_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] alu_cs_o,
   output logic       illegal_o
);

   // Translate funct into an ALU operation; unknown codes are flagged illegal
   always_comb begin
      alu_cs_o  = ALU_AND;
      illegal_o = 1'b0;
      case (funct_i)
         FN_ADD:  alu_cs_o = ALU_ADD;
         FN_SUB:  alu_cs_o = ALU_SUB;
         FN_AND:  alu_cs_o = ALU_AND;
         FN_OR:   alu_cs_o = ALU_OR;
         default: begin
            alu_cs_o  = ALU_AND;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM. Sequences one instruction at a time from
// FETCH to write-back, drives the ALU control code and all datapath enables,
// bounds every memory wait, and counts retired instructions. Outputs are
// decoded from the state register so an asynchronous reset drops them at once.
module mc_control
   import mips_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [31:0]      alu_result,
   input  logic             mem_ready,
   output logic [2:0]       alu_cs,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic             pc_write,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   // Wait counter only has to hold 0 .. MEM_TIMEOUT-1
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               retire_s;
   logic               wait_lim_s;
   logic [2:0]         fn_alu_cs_s;
   logic               fn_illegal_s;

   mc_alu_dec u_alu_dec (
      .funct_i   (funct),
      .alu_cs_o  (fn_alu_cs_s),
      .illegal_o (fn_illegal_s)
   );

   assign wait_lim_s = (wait_q == WAIT_LIMIT);
   assign retired    = retired_q;

   // State, wait counter and retired counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // Next-state sequencing, memory wait bounding and retirement strobe
   always_comb begin
      state_d  = state_q;
      wait_d   = '0;
      retire_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
            else     state_d = S_IDLE;
         end
         S_FETCH: begin
            if (mem_ready)       state_d = S_DECODE;
            else if (wait_lim_s) state_d = S_TRAP;
            else                 wait_d  = wait_q + WAIT_W'(1);
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_TRAP;
            endcase
         end
         S_EXEC: begin
            if (fn_illegal_s) state_d = S_TRAP;
            else              state_d = S_RWB;
         end
         S_MEMADR: begin
            if (opcode == OP_LW) state_d = S_MEMRD;
            else                 state_d = S_MEMWR;
         end
         S_MEMRD: begin
            if (mem_ready)       state_d = S_MEMWB;
            else if (wait_lim_s) state_d = S_TRAP;
            else                 wait_d  = wait_q + WAIT_W'(1);
         end
         S_MEMWR: begin
            if (mem_ready) begin
               state_d  = S_FETCH;
               retire_s = 1'b1;
            end else if (wait_lim_s) begin
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_RWB, S_MEMWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
         end
         S_ADDIEX: state_d = S_ADDIWB;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_TRAP;
      endcase
      retired_d = retire_s ? (retired_q + CNT_W'(1)) : retired_q;
   end

   // Datapath control decode; everything idles at 0 unless the state drives it
   always_comb begin
      alu_cs     = ALU_AND;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_REG;
      pc_src     = PC_SRC_ALU;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      trap       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            alu_cs    = ALU_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = SRC_B_IMM_SH2;
            alu_cs    = ALU_ADD;
         end
         S_EXEC: begin
            alu_src_a = SRC_A_REG;
            alu_cs    = fn_alu_cs_s;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = SRC_A_REG;
            alu_src_b = SRC_B_IMM;
            alu_cs    = ALU_ADD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = SRC_A_REG;
            alu_cs    = ALU_SUB;
            pc_src    = PC_SRC_ALUOUT;
            pc_write  = (alu_result == 32'h0000_0000);
         end
         S_JUMP: begin
            pc_src   = PC_SRC_JUMP;
            pc_write = 1'b1;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_TRAP:   trap      = 1'b1;
         default: begin
            alu_cs = ALU_AND;
         end
      endcase
   end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected control vectors are
// queued by each scenario and compared as the DUT steps through states.
module tb_mc_control;

   localparam int CNT_W       = 3;
   localparam int MEM_TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             rst, run, mem_ready;
   logic [5:0]       opcode, funct;
   logic [31:0]      alu_result;
   logic [2:0]       alu_cs;
   logic             alu_src_a;
   logic [1:0]       alu_src_b, pc_src;
   logic             pc_write, ir_write, iord, mem_read, mem_write;
   logic             reg_write, reg_dst, mem_to_reg, trap;
   logic [CNT_W-1:0] retired;

   mc_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
      .alu_result(alu_result), .mem_ready(mem_ready), .alu_cs(alu_cs),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // {alu_cs, src_a, src_b, pc_src, pcw, irw, iord, mr, mw, rw, rd, m2r, trap}
   wire [16:0] act = {alu_cs, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
                      mem_read, mem_write, reg_write, reg_dst, mem_to_reg, trap};

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [16:0] v;
      logic [16:0] m;
      string       nm;
   } exp_t;
   exp_t sb[$];

   logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h24, 6'h25};
   logic [2:0] css [4] = '{3'b010, 3'b011, 3'b000, 3'b001};

   // en = {pcw, irw, iord, mr, mw, rw, rd, m2r, trap}
   function automatic logic [16:0] mk(input logic [2:0] cs, input logic a, input logic [1:0] b,
                                      input logic [1:0] pcs, input logic [8:0] en);
      return {cs, a, b, pcs, en};
   endfunction

   function automatic logic [16:0] v_fetch(input logic r);
      return mk(3'b010, 1'b0, 2'b01, 2'b00, {r, r, 1'b0, 1'b1, 5'b00000});
   endfunction
   function automatic logic [16:0] v_branch(input logic p);
      return mk(3'b011, 1'b1, 2'b00, 2'b01, {p, 8'b00000000});
   endfunction
   function automatic logic [16:0] v_exec(input logic [2:0] cs);
      return mk(cs, 1'b1, 2'b00, 2'b00, 9'b000000000);
   endfunction

   logic [16:0] v_idle, v_decode, v_rwb, v_memadr, v_memrd, v_memwb, v_memwr;
   logic [16:0] v_jump, v_addiex, v_addiwb, v_trap;
   initial begin
      v_idle   = 17'h00000;
      v_decode = mk(3'b010, 1'b0, 2'b11, 2'b00, 9'b000000000);
      v_rwb    = mk(3'b000, 1'b0, 2'b00, 2'b00, 9'b000001100);
      v_memadr = mk(3'b010, 1'b1, 2'b10, 2'b00, 9'b000000000);
      v_memrd  = mk(3'b000, 1'b0, 2'b00, 2'b00, 9'b001100000);
      v_memwb  = mk(3'b000, 1'b0, 2'b00, 2'b00, 9'b000001010);
      v_memwr  = mk(3'b000, 1'b0, 2'b00, 2'b00, 9'b001010000);
      v_jump   = mk(3'b000, 1'b0, 2'b00, 2'b10, 9'b100000000);
      v_addiex = mk(3'b010, 1'b1, 2'b10, 2'b00, 9'b000000000);
      v_addiwb = mk(3'b000, 1'b0, 2'b00, 2'b00, 9'b000001000);
      v_trap   = mk(3'b000, 1'b0, 2'b00, 2'b00, 9'b000000001);
   end

   task automatic push(input logic [16:0] v, input string nm);
      sb.push_back('{v, 17'h1FFFF, nm});
   endtask

   // One clock cycle: drive memory/ALU inputs, then pop and compare the expected vector
   task automatic cyc(input logic rdy, input logic [31:0] res);
      exp_t e;
      @(negedge clk);
      mem_ready  = rdy;
      alu_result = res;
      #1;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty: act=%h required=queued entry", act);
      end else begin
         e = sb.pop_front();
         if ((act & e.m) !== (e.v & e.m)) begin
            n_fail++;
            $display("FAIL %s: act=%h required=%h", e.nm, act & e.m, e.v & e.m);
         end
      end
   endtask

   task automatic chk_retired(input logic [CNT_W-1:0] exp, input string nm);
      @(posedge clk);
      #1;
      n_tests++;
      if (retired !== exp) begin
         n_fail++;
         $display("FAIL %s: retired=%0d required=%0d", nm, retired, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; alu_result = 32'h0;
      opcode = 6'h00; funct = 6'h00;
      #1;
      n_tests++;
      if (act !== 17'h00000 || retired !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: act=%h retired=%0d required=00000/0", act, retired);
      end
      @(negedge clk);
      rst = 1'b0;
      push(v_idle, "idle_hold");
      cyc(1'b1, 32'h0);
   endtask

   task automatic test_reset();
      do_reset();
      push(v_idle, "idle_hold2");
      cyc(1'b0, 32'hFFFF_FFFF);
   endtask

   task automatic test_rtype();
      do_reset();
      run = 1'b1;
      opcode = 6'h00;
      for (int i = 0; i < 4; i++) begin
         funct = fns[i];
         push(v_fetch(1'b1), "r_fetch");
         push(v_decode, "r_decode");
         push(v_exec(css[i]), "r_exec");
         push(v_rwb, "r_rwb");
         cyc(1'b1, 32'h0);
         run = 1'b0;
         for (int k = 0; k < 3; k++) cyc(1'b1, 32'h0);
         chk_retired(3'(i + 1), "r_retired");
      end
   endtask

   task automatic test_mem_imm_jump();
      do_reset();
      run = 1'b1;
      opcode = 6'h23;
      push(v_fetch(1'b1), "lw_fetch");
      push(v_decode, "lw_decode");
      push(v_memadr, "lw_memadr");
      for (int k = 0; k < 4; k++) push(v_memrd, "lw_memrd");
      push(v_memwb, "lw_memwb");
      cyc(1'b1, 32'h0);
      run = 1'b0;
      cyc(1'b1, 32'h0);
      cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      cyc(1'b1, 32'h0);
      cyc(1'b1, 32'h0);
      chk_retired(3'd1, "lw_retired");
      opcode = 6'h2B;
      push(v_fetch(1'b1), "sw_fetch");
      push(v_decode, "sw_decode");
      push(v_memadr, "sw_memadr");
      push(v_memwr, "sw_memwr");
      for (int k = 0; k < 4; k++) cyc(1'b1, 32'h0);
      chk_retired(3'd2, "sw_retired");
      opcode = 6'h08;
      push(v_fetch(1'b1), "addi_fetch");
      push(v_decode, "addi_decode");
      push(v_addiex, "addi_ex");
      push(v_addiwb, "addi_wb");
      for (int k = 0; k < 4; k++) cyc(1'b1, 32'h0);
      chk_retired(3'd3, "addi_retired");
      opcode = 6'h02;
      push(v_fetch(1'b1), "j_fetch");
      push(v_decode, "j_decode");
      push(v_jump, "j_jump");
      for (int k = 0; k < 3; k++) cyc(1'b1, 32'h0);
      chk_retired(3'd4, "j_retired");
   endtask

   task automatic test_beq();
      do_reset();
      run = 1'b1;
      opcode = 6'h04;
      push(v_fetch(1'b1), "beq_fetch");
      push(v_decode, "beq_decode");
      push(v_branch(1'b1), "beq_taken");
      cyc(1'b1, 32'h5);
      run = 1'b0;
      cyc(1'b1, 32'h5);
      cyc(1'b1, 32'h0);
      chk_retired(3'd1, "beq_retired1");
      push(v_fetch(1'b1), "beq_fetch2");
      push(v_decode, "beq_decode2");
      push(v_branch(1'b0), "beq_not_taken");
      cyc(1'b1, 32'h0);
      cyc(1'b1, 32'h0);
      cyc(1'b1, 32'h5);
      chk_retired(3'd2, "beq_retired2");
   endtask

   task automatic test_illegal();
      do_reset();
      run = 1'b1;
      opcode = 6'h00;
      funct = 6'h2A;
      push(v_fetch(1'b1), "ill_fn_fetch");
      push(v_decode, "ill_fn_decode");
      sb.push_back('{v_exec(3'b000), 17'h03FFF, "ill_fn_exec"});
      for (int k = 0; k < 3; k++) push(v_trap, "ill_fn_trap");
      for (int k = 0; k < 6; k++) cyc(1'b1, 32'h0);
      chk_retired(3'd0, "ill_fn_retired");
      do_reset();
      run = 1'b1;
      opcode = 6'h3F;
      push(v_fetch(1'b1), "ill_op_fetch");
      push(v_decode, "ill_op_decode");
      push(v_trap, "ill_op_trap");
      push(v_trap, "ill_op_trap_held");
      for (int k = 0; k < 4; k++) cyc(1'b1, 32'h0);
      chk_retired(3'd0, "ill_op_retired");
   endtask

   task automatic test_timeout();
      do_reset();
      run = 1'b1;
      opcode = 6'h00;
      funct = 6'h20;
      for (int k = 0; k < 4; k++) push(v_fetch(1'b0), "to_fetch_wait");
      push(v_trap, "to_trap");
      push(v_trap, "to_trap_held");
      for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0);
      cyc(1'b1, 32'h0);
      cyc(1'b1, 32'h0);
      do_reset();
      run = 1'b1;
      opcode = 6'h00;
      funct = 6'h20;
      for (int k = 0; k < 3; k++) push(v_fetch(1'b0), "lim_fetch_wait");
      push(v_fetch(1'b1), "lim_fetch_ready");
      push(v_decode, "lim_decode");
      push(v_exec(3'b010), "lim_exec");
      push(v_rwb, "lim_rwb");
      for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 32'h0);
      chk_retired(3'd1, "lim_retired");
   endtask

   task automatic test_async_rst();
      do_reset();
      run = 1'b1;
      opcode = 6'h02;
      push(v_fetch(1'b1), "ar_j_fetch");
      push(v_decode, "ar_j_decode");
      push(v_jump, "ar_j_jump");
      cyc(1'b1, 32'h0);
      run = 1'b0;
      cyc(1'b1, 32'h0);
      cyc(1'b1, 32'h0);
      chk_retired(3'd1, "ar_retired_before");
      opcode = 6'h2B;
      push(v_fetch(1'b1), "ar_sw_fetch");
      push(v_decode, "ar_sw_decode");
      push(v_memadr, "ar_sw_memadr");
      push(v_memwr, "ar_sw_memwr");
      for (int k = 0; k < 3; k++) cyc(1'b1, 32'h0);
      cyc(1'b0, 32'h0);
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if (mem_write !== 1'b0 || act !== 17'h00000 || retired !== 3'd0) begin
         n_fail++;
         $display("FAIL async_rst: act=%h mem_write=%b retired=%0d required=00000/0/0",
                  act, mem_write, retired);
      end
      @(negedge clk);
      rst = 1'b0;
      push(v_idle, "ar_idle_after");
      cyc(1'b1, 32'h0);
   endtask

   task automatic test_wrap();
      do_reset();
      run = 1'b1;
      opcode = 6'h02;
      for (int i = 0; i < 9; i++) begin
         push(v_fetch(1'b1), "wrap_fetch");
         push(v_decode, "wrap_decode");
         push(v_jump, "wrap_jump");
         for (int k = 0; k < 3; k++) cyc(1'b1, 32'h0);
         chk_retired(3'(i + 1), "wrap_retired");
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; alu_result = 32'h0;
      opcode = 6'h00; funct = 6'h00;
      test_reset();
      test_rtype();
      test_mem_imm_jump();
      test_beq();
      test_illegal();
      test_timeout();
      test_async_rst();
      test_wrap();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: leftover=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t required=finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
